// File: rtl/mbtrain_pkg.sv
// Shared types and constants for the MBTRAIN sideband arbiter and its owner selector.
package mbtrain_pkg;

    localparam int unsigned SB_MSG_W = 4;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StSend     = 2'd1,
        StWaitFall = 2'd2,
        StDone     = 2'd3
    } sb_state_e;

    // Encoder owner
    typedef enum logic {
        OwnTx = 1'b0,
        OwnRx = 1'b1
    } sb_owner_e;

    // Sideband message codes
    localparam logic [SB_MSG_W-1:0] SbSelfcalStartReq = 4'b0001;
    localparam logic [SB_MSG_W-1:0] SbSelfcalEndResp  = 4'b0010;

endpackage

// File: rtl/mbtrain_sb_prio_sel.sv
// Combinational owner select between the TX- and RX-side requesters.
// Define MBTRAIN_SB_ARB_RR_EN for round-robin on contention; otherwise RX always beats TX.
module mbtrain_sb_prio_sel
    import mbtrain_pkg::*;
(
    input  logic      tx_valid_i,
    input  logic      rx_valid_i,
    input  sb_owner_e last_owner_i,
    output sb_owner_e owner_o
);

`ifdef MBTRAIN_SB_ARB_RR_EN
    // On contention hand the encoder to whoever did not own it last
    always_comb begin
        owner_o = OwnTx;
        if (tx_valid_i && rx_valid_i) begin
            owner_o = (last_owner_i == OwnRx) ? OwnTx : OwnRx;
        end else if (rx_valid_i) begin
            owner_o = OwnRx;
        end
    end
`else
    // History and TX valid do not affect a fixed-priority pick
    logic unused_sel;
    assign unused_sel = ^{last_owner_i, tx_valid_i};

    // Responses first so they never queue behind new requests
    always_comb begin
        owner_o = rx_valid_i ? OwnRx : OwnTx;
    end
`endif

endmodule

// File: rtl/mbtrain_sb_arbiter.sv
// Shares the MBTRAIN sideband encoder between the TX-side and RX-side sub-FSMs: grants one owner,
// drives its latched message, waits for encoder busy to fall and reports done or timeout.
// Optional feature macro: MBTRAIN_SB_ARB_RR_EN (round-robin arbitration on contention).
module mbtrain_sb_arbiter
    import mbtrain_pkg::*;
#(
    parameter int unsigned MSG_W       = SB_MSG_W,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned CNT_W       = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_req_tx_valid,
    input  logic [MSG_W-1:0] i_req_tx_msg,
    input  logic             i_req_rx_valid,
    input  logic [MSG_W-1:0] i_req_rx_msg,
    input  logic             i_sb_busy,
    output logic             o_sb_valid,
    output logic [MSG_W-1:0] o_sb_msg,
    output logic             o_grant_tx,
    output logic             o_grant_rx,
    output logic             o_done_tx,
    output logic             o_done_rx,
    output logic             o_timeout_err
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYC - 1);

    sb_state_e        state_q, state_d;
    sb_owner_e        owner_q, owner_d;
    sb_owner_e        sel_owner;
    sb_owner_e        last_owner;
    logic             busy_q;
    logic             busy_fall;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [MSG_W-1:0] msg_q, msg_d;
    logic             grant_tx_q, grant_tx_d;
    logic             grant_rx_q, grant_rx_d;
    logic             done_tx_q, done_tx_d;
    logic             done_rx_q, done_rx_d;
    logic             tmo_q, tmo_d;

`ifdef MBTRAIN_SB_ARB_RR_EN
    sb_owner_e last_owner_q, last_owner_d;

    // Owner of the most recent completed transfer, for round-robin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_q <= OwnRx;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

    assign last_owner = last_owner_q;
`else
    assign last_owner = OwnRx;
`endif

    assign busy_fall = busy_q & ~i_sb_busy;

    mbtrain_sb_prio_sel u_prio_sel (
        .tx_valid_i   (i_req_tx_valid),
        .rx_valid_i   (i_req_rx_valid),
        .last_owner_i (last_owner),
        .owner_o      (sel_owner)
    );

    // Next-state and registered-output logic; enable low overrides everything
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = '0;
        valid_d    = valid_q;
        msg_d      = msg_q;
        grant_tx_d = grant_tx_q;
        grant_rx_d = grant_rx_q;
        done_tx_d  = 1'b0;
        done_rx_d  = 1'b0;
        tmo_d      = tmo_q;
`ifdef MBTRAIN_SB_ARB_RR_EN
        last_owner_d = last_owner_q;
`endif
        if (!i_en) begin
            state_d    = StIdle;
            valid_d    = 1'b0;
            msg_d      = '0;
            grant_tx_d = 1'b0;
            grant_rx_d = 1'b0;
            tmo_d      = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if ((i_req_tx_valid || i_req_rx_valid) && !tmo_q) begin
                        owner_d    = sel_owner;
                        msg_d      = (sel_owner == OwnRx) ? i_req_rx_msg : i_req_tx_msg;
                        valid_d    = 1'b1;
                        grant_tx_d = (sel_owner == OwnTx);
                        grant_rx_d = (sel_owner == OwnRx);
                        state_d    = StSend;
                    end
                end
                StSend: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        tmo_d      = 1'b1;
                        valid_d    = 1'b0;
                        msg_d      = '0;
                        grant_tx_d = 1'b0;
                        grant_rx_d = 1'b0;
                        state_d    = StIdle;
                    end else if (i_sb_busy) begin
                        valid_d = 1'b0;
                        state_d = StWaitFall;
                    end
                end
                StWaitFall: begin
                    cnt_d = cnt_q + 1'b1;
                    // A fall on the final cycle still counts as delivered
                    if (busy_fall) begin
                        done_tx_d  = (owner_q == OwnTx);
                        done_rx_d  = (owner_q == OwnRx);
                        msg_d      = '0;
                        grant_tx_d = 1'b0;
                        grant_rx_d = 1'b0;
                        state_d    = StDone;
                    end else if (cnt_q == CntLast) begin
                        tmo_d      = 1'b1;
                        msg_d      = '0;
                        grant_tx_d = 1'b0;
                        grant_rx_d = 1'b0;
                        state_d    = StIdle;
                    end
                end
                StDone: begin
`ifdef MBTRAIN_SB_ARB_RR_EN
                    last_owner_d = owner_q;
`endif
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            owner_q    <= OwnRx;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            msg_q      <= '0;
            grant_tx_q <= 1'b0;
            grant_rx_q <= 1'b0;
            done_tx_q  <= 1'b0;
            done_rx_q  <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            busy_q     <= i_sb_busy;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            msg_q      <= msg_d;
            grant_tx_q <= grant_tx_d;
            grant_rx_q <= grant_rx_d;
            done_tx_q  <= done_tx_d;
            done_rx_q  <= done_rx_d;
            tmo_q      <= tmo_d;
        end
    end

    assign o_sb_valid    = valid_q;
    assign o_sb_msg      = msg_q;
    assign o_grant_tx    = grant_tx_q;
    assign o_grant_rx    = grant_rx_q;
    assign o_done_tx     = done_tx_q;
    assign o_done_rx     = done_rx_q;
    assign o_timeout_err = tmo_q;

endmodule

// File: tb/tb_mbtrain_sb_arbiter.sv
// Self-checking bench for mbtrain_sb_arbiter: directed scenarios with literal expectations plus
// randomized requesters/encoder, all cross-checked every cycle against a transaction-level model.
module tb_mbtrain_sb_arbiter;

    localparam int TMO = 40;
`ifdef MBTRAIN_SB_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk, rst_n, en, txv, rxv, busy;
    logic [3:0] txm, rxm;
    logic       o_sb_valid, o_grant_tx, o_grant_rx, o_done_tx, o_done_rx, o_timeout_err;
    logic [3:0] o_sb_msg;

    int n_chk  = 0;
    int n_fail = 0;

    mbtrain_sb_arbiter #(
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_en           (en),
        .i_req_tx_valid (txv),
        .i_req_tx_msg   (txm),
        .i_req_rx_valid (rxv),
        .i_req_rx_msg   (rxm),
        .i_sb_busy      (busy),
        .o_sb_valid     (o_sb_valid),
        .o_sb_msg       (o_sb_msg),
        .o_grant_tx     (o_grant_tx),
        .o_grant_rx     (o_grant_rx),
        .o_done_tx      (o_done_tx),
        .o_done_rx      (o_done_rx),
        .o_timeout_err  (o_timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    int         m_own;      // -1 none, 0 TX, 1 RX
    int         m_last;     // last completed owner
    int         m_dn_own;
    int         m_age;      // cycles since grant
    bit         m_valid, m_tmo, m_cool, m_pbusy, m_dtx, m_drx;
    logic [3:0] m_msg;

    task automatic model_reset();
        m_own = -1; m_last = 1; m_dn_own = 1; m_age = 0;
        m_valid = 0; m_tmo = 0; m_cool = 0; m_pbusy = 0; m_dtx = 0; m_drx = 0;
        m_msg = 4'h0;
    endtask

    task automatic model_abort();
        m_tmo = 1; m_own = -1; m_valid = 0; m_msg = 4'h0;
    endtask

    task automatic model_step();
        bit fall, expired;
        int p;
        fall  = m_pbusy && !busy;
        m_dtx = 0;
        m_drx = 0;
        if (!en) begin
            m_own = -1; m_valid = 0; m_msg = 4'h0; m_tmo = 0; m_cool = 0;
        end else if (m_cool) begin
            m_last = m_dn_own;
            m_cool = 0;
        end else if (m_own < 0) begin
            if ((txv || rxv) && !m_tmo) begin
                if (txv && rxv) p = RR ? (m_last == 1 ? 0 : 1) : 1;
                else            p = rxv ? 1 : 0;
                m_own = p; m_msg = (p == 1) ? rxm : txm; m_valid = 1; m_age = 0;
            end
        end else begin
            expired = (m_age + 1 >= TMO);
            if (m_valid) begin
                if (expired)   model_abort();
                else if (busy) m_valid = 0;
            end else if (fall) begin
                if (m_own == 0) m_dtx = 1;
                else            m_drx = 1;
                m_dn_own = m_own; m_own = -1; m_msg = 4'h0; m_cool = 1;
            end else if (expired) begin
                model_abort();
            end
            m_age++;
        end
        m_pbusy = busy;
    endtask

    // Compare DUT against the model mid-cycle, then advance the model with the inputs
    // that the next rising edge will sample
    initial begin : cmp
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_reset();
            end else begin
                chk("grant_tx", o_grant_tx, m_own == 0);
                chk("grant_rx", o_grant_rx, m_own == 1);
                chk("sb_valid", o_sb_valid, m_valid);
                chk("sb_msg", o_sb_msg, m_msg);
                chk("done_tx", o_done_tx, m_dtx);
                chk("done_rx", o_done_rx, m_drx);
                chk("timeout_err", o_timeout_err, m_tmo);
                chk("grant_onehot", o_grant_tx & o_grant_rx, 0);
                chk("valid_has_grant", o_sb_valid & ~(o_grant_tx | o_grant_rx), 0);
                chk("done_onehot", o_done_tx & o_done_rx, 0);
                model_step();
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b1; txv = 1'b0; rxv = 1'b0; busy = 1'b0; txm = 4'h0; rxm = 4'h0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Current owner 'side' with message 'm': serve one busy pulse, expect its done, release it
    task automatic xfer(input int side, input logic [3:0] m, input string tag);
        chk({tag, "_gtx"}, o_grant_tx, side == 0);
        chk({tag, "_grx"}, o_grant_rx, side == 1);
        chk({tag, "_msg"}, o_sb_msg, m);
        busy = 1'b1;
        tick();
        busy = 1'b0;
        tick();
        chk({tag, "_done"}, (side == 0) ? o_done_tx : o_done_rx, 1);
        if (side == 0) txv = 1'b0;
        else           rxv = 1'b0;
    endtask

    int first, k;
    int b_wait = 0, b_on = 0;
    bit b_armed = 0;

    initial begin : main
        rst_n = 1'b0; en = 1'b0; txv = 1'b0; rxv = 1'b0; busy = 1'b0; txm = 4'h0; rxm = 4'h0;
        tick();

        // 1: TX alone, busy high for 3 cycles starting two cycles after grant
        do_reset();
        chk("rst_valid", o_sb_valid, 0);
        chk("rst_grants", {o_grant_tx, o_grant_rx}, 0);
        chk("rst_done_tmo", {o_done_tx, o_done_rx, o_timeout_err}, 0);
        txv = 1'b1; txm = 4'h1;
        tick();
        chk("t1_valid", o_sb_valid, 1);
        chk("t1_msg", o_sb_msg, 4'h1);
        chk("t1_gtx", o_grant_tx, 1);
        tick();
        busy = 1'b1;
        tick();
        chk("t1_valid_drop", o_sb_valid, 0);
        tick();
        tick();
        busy = 1'b0;
        tick();
        chk("t1_done", o_done_tx, 1);
        chk("t1_gtx_drop", o_grant_tx, 0);
        txv = 1'b0;
        tick();
        chk("t1_done_pulse", o_done_tx, 0);

        // 2: contention
        do_reset();
        txv = 1'b1; txm = 4'h1; rxv = 1'b1; rxm = 4'h2;
        tick();
        first = RR ? 0 : 1;
        xfer(first, (first == 1) ? 4'h2 : 4'h1, "t2_first");
        tick();
        tick();
        xfer(1 - first, (first == 1) ? 4'h1 : 4'h2, "t2_second");
        txv = 1'b1; rxv = 1'b1;
        tick();
        tick();
        xfer(RR ? 0 : 1, RR ? 4'h1 : 4'h2, "t2_third");
        txv = 1'b0; rxv = 1'b0;
        tick();

        // 3: busy never rises -> timeout, sticky until enable drops
        do_reset();
        txv = 1'b1; txm = 4'h3;
        tick();
        chk("t3_gtx", o_grant_tx, 1);
        k = -1;
        for (int i = 1; i <= 2 * TMO; i++) begin
            tick();
            if (o_timeout_err) begin
                k = i;
                break;
            end
        end
        chk("t3_latency", k, TMO);
        chk("t3_valid", o_sb_valid, 0);
        chk("t3_grant", o_grant_tx, 0);
        repeat (5) tick();
        chk("t3_no_regrant", o_grant_tx, 0);
        chk("t3_sticky", o_timeout_err, 1);
        en = 1'b0;
        tick();
        chk("t3_cleared", o_timeout_err, 0);
        en = 1'b1;
        tick();
        xfer(0, 4'h3, "t3_after");
        tick();

        // 4: enable dropped in WAIT_FALL while busy falls
        do_reset();
        txv = 1'b1; txm = 4'h4;
        tick();
        busy = 1'b1;
        tick();
        busy = 1'b0; en = 1'b0;
        tick();
        chk("t4_outs", {o_sb_valid, o_grant_tx, o_grant_rx, o_done_tx, o_done_rx}, 0);
        chk("t4_msg", o_sb_msg, 0);
        en = 1'b1;
        tick();
        xfer(0, 4'h4, "t4_regrant");
        tick();

        // 5: message change after grant is ignored
        do_reset();
        txv = 1'b1; txm = 4'h1;
        tick();
        txm = 4'h5;
        tick();
        chk("t5_msg_send", o_sb_msg, 4'h1);
        busy = 1'b1;
        tick();
        chk("t5_msg_wait", o_sb_msg, 4'h1);
        busy = 1'b0;
        tick();
        chk("t5_done", o_done_tx, 1);
        txv = 1'b0;
        tick();

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (txv && o_done_tx) txv = 1'b0;
            else if (!txv) begin
                if ($urandom_range(0, 3) == 0) begin txv = 1'b1; txm = 4'($urandom); end
            end else if ($urandom_range(0, 7) == 0) txm = 4'($urandom);
            if (rxv && o_done_rx) rxv = 1'b0;
            else if (!rxv) begin
                if ($urandom_range(0, 3) == 0) begin rxv = 1'b1; rxm = 4'($urandom); end
            end else if ($urandom_range(0, 7) == 0) rxm = 4'($urandom);
            if (!o_sb_valid) b_armed = 0;
            else if (!b_armed) begin
                b_armed = 1;
                if ($urandom_range(0, 9) != 0) b_wait = $urandom_range(1, 4);
            end
            if (b_wait > 0) begin
                b_wait--;
                if (b_wait == 0) b_on = $urandom_range(1, 4);
            end
            busy = (b_on > 0);
            if (b_on > 0) b_on--;
            if (!en) en = 1'b1;
            else if ($urandom_range(0, 199) == 0 ||
                     (o_timeout_err && $urandom_range(0, 15) == 0)) en = 1'b0;
            tick();
        end
        txv = 1'b0; rxv = 1'b0; busy = 1'b0; en = 1'b1;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
